// File: rtl/receiver3b.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | receiver3b: oversampling 8N1 receiver; packs 3 bytes into a 24-bit word |
// | Optional: RX_TIMEOUT_EN drops a stale partial word after idle time.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module receiver3b #(
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [0:23] data_out,
  output logic        data_valid,
  output logic        frame_error,
  output logic        timeout,
  output logic        busy,
  output logic [1:0]  state_out
);

  localparam int c_cnt_w = $clog2(OVERSAMPLE);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full_last = c_cnt_w'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic                 r_rx_prev;
  logic [c_cnt_w-1:0]   r_sample_cnt;
  logic [2:0]           r_bit_cnt;
  logic [1:0]           r_byte_cnt;
  logic [0:23]          r_buf;
  logic                 w_fall;
  logic                 w_half;
  logic                 w_full;
  logic                 w_to_fire;
  logic [4:0]           w_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fall      = r_rx_prev & ~r_rx_s;
    w_half      = (r_sample_cnt == c_half_last);
    w_full      = (r_sample_cnt == c_full_last);
    // {byte_cnt, bit_cnt} is 8*byte_cnt + bit_cnt; first received bit lands at 23
    w_idx       = 5'd23 - {r_byte_cnt, r_bit_cnt};
    case (r_state)
      IDLE:    if (w_fall) w_state_nxt = START;
      START:   if (w_half) w_state_nxt = r_rx_s ? IDLE : DATA;
      DATA:    if (w_full && (r_bit_cnt == 3'd7)) w_state_nxt = STOP;
      STOP:    if (w_full) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_buf        <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sample_cnt <= '0;
          if (w_to_fire) r_byte_cnt <= '0;
        end
        START: begin
          if (w_half) begin
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
          end else begin
            r_sample_cnt <= r_sample_cnt + c_cnt_w'(1);
          end
        end
        DATA: begin
          if (w_full) begin
            r_sample_cnt <= '0;
            r_buf[w_idx] <= r_rx_s;
            if (r_bit_cnt != 3'd7) r_bit_cnt <= r_bit_cnt + 3'd1;
          end else begin
            r_sample_cnt <= r_sample_cnt + c_cnt_w'(1);
          end
        end
        STOP: begin
          if (w_full) begin
            r_sample_cnt <= '0;
            if (r_rx_s) begin
              if (r_byte_cnt == 2'd2) begin
                data_out   <= r_buf;
                data_valid <= 1'b1;
                r_byte_cnt <= '0;
              end else begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
              end
            end else begin
              frame_error <= 1'b1;
              r_byte_cnt  <= '0;
            end
          end else begin
            r_sample_cnt <= r_sample_cnt + c_cnt_w'(1);
          end
        end
        default: r_sample_cnt <= '0;
      endcase
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int c_to_limit = TIMEOUT_BITS * OVERSAMPLE;
  localparam int c_to_w     = $clog2(c_to_limit + 1);

  logic [c_to_w-1:0] r_idle_cnt;

  assign w_to_fire = (r_state == IDLE) && (r_byte_cnt != 2'd0) && !w_fall &&
                     (r_idle_cnt == c_to_w'(c_to_limit - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
      timeout    <= 1'b0;
    end else begin
      timeout <= w_to_fire;
      if ((r_state != IDLE) || (r_byte_cnt == 2'd0) || w_fall || w_to_fire) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + c_to_w'(1);
      end
    end
  end
`else
  assign w_to_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign busy      = (r_state != IDLE) || (r_byte_cnt != 2'd0);
  assign state_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_receiver3b.sv
`default_nettype none
// Directed bench for receiver3b at OVERSAMPLE=16 with a pulse monitor.
`timescale 1ns/1ps
module tb_receiver3b;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [0:23] data_out;
  logic        data_valid;
  logic        frame_error;
  logic        timeout;
  logic        busy;
  logic [1:0]  state_out;

  receiver3b #(.OVERSAMPLE(OS), .TIMEOUT_BITS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .timeout    (timeout),
    .busy       (busy),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_to    = 0;
  int n_overlap = 0;
  logic [23:0] words[$];

  always @(negedge clk) begin
    if (data_valid) begin
      n_valid++;
      words.push_back(data_out);
    end
    if (frame_error) n_ferr++;
    if (timeout) n_to++;
    if ((int'(data_valid) + int'(frame_error) + int'(timeout)) > 1) n_overlap++;
  end

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (OS) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int v0, f0, t0;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data_out", data_out, 24'h0);
    chk("rst_valid", 24'(data_valid), 24'h0);
    chk("rst_ferr", 24'(frame_error), 24'h0);
    chk("rst_timeout", 24'(timeout), 24'h0);
    chk("rst_busy", 24'(busy), 24'h0);
    chk("rst_state", 24'(state_out), 24'h0);
    rst_n = 1'b1;
    idle(20);

    // Clean word
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h81, 1'b1);
    idle(4);
    #1;
    chk("clean_valid_cnt", 24'(n_valid - v0), 24'd1);
    chk("clean_word", data_out, 24'h813CA5);
    chk("clean_ferr_cnt", 24'(n_ferr - f0), 24'd0);
    chk("clean_busy", 24'(busy), 24'h0);
    chk("clean_state", 24'(state_out), 24'h0);

    // Glitch: 4 clocks low while idle
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("glitch_in_start", 24'(state_out), 24'd1);
    repeat (6) @(negedge clk);
    #1;
    chk("glitch_back_idle", 24'(state_out), 24'd0);
    chk("glitch_busy", 24'(busy), 24'h0);
    idle(20);
    chk("glitch_no_pulse", 24'((n_valid - v0) + (n_ferr - f0)), 24'd0);

    // Framing error on second byte, then a good word
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    idle(2 * OS);
    #1;
    chk("ferr_cnt", 24'(n_ferr - f0), 24'd1);
    chk("ferr_data_held", data_out, 24'h813CA5);
    chk("ferr_busy", 24'(busy), 24'h0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    idle(4);
    #1;
    chk("ferr_then_valid_cnt", 24'(n_valid - v0), 24'd1);
    chk("ferr_then_word", data_out, 24'h030201);

    // Reset during DATA of byte 1
    send_byte(8'h77, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_rst_state", 24'(state_out), 24'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_data_out", data_out, 24'h0);
    chk("midrst_busy", 24'(busy), 24'h0);
    chk("midrst_state", 24'(state_out), 24'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * OS);
    v0 = n_valid;
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    idle(4);
    #1;
    chk("after_rst_valid_cnt", 24'(n_valid - v0), 24'd1);
    chk("after_rst_word", data_out, 24'hAA00FF);

    // Back-to-back words
    v0 = n_valid;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h9A, 1'b1);
    send_byte(8'hBC, 1'b1);
    send_byte(8'hDE, 1'b1);
    idle(4);
    #1;
    chk("b2b_valid_cnt", 24'(n_valid - v0), 24'd2);
    if (n_valid - v0 >= 2) begin
      chk("b2b_word0", words[v0], 24'h563412);
      chk("b2b_word1", words[v0 + 1], 24'hDEBC9A);
    end

    // Idle gap of 12 bit periods after a single byte
    v0 = n_valid; t0 = n_to;
    send_byte(8'h55, 1'b1);
    idle(12 * OS);
    #1;
`ifdef RX_TIMEOUT_EN
    chk("to_pulse_cnt", 24'(n_to - t0), 24'd1);
    chk("to_busy_cleared", 24'(busy), 24'h0);
`else
    chk("to_pulse_cnt", 24'(n_to - t0), 24'd0);
    chk("to_partial_held", 24'(busy), 24'h1);
`endif
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(4);
    #1;
`ifndef RX_TIMEOUT_EN
    chk("gap_valid_cnt", 24'(n_valid - v0), 24'd1);
    chk("gap_word", data_out, 24'h020155);
`endif
    send_byte(8'h03, 1'b1);
    idle(4);
    #1;
`ifdef RX_TIMEOUT_EN
    chk("to_valid_cnt", 24'(n_valid - v0), 24'd1);
    chk("to_word", data_out, 24'h030201);
    chk("to_final_busy", 24'(busy), 24'h0);
`else
    chk("gap_valid_cnt_final", 24'(n_valid - v0), 24'd1);
    chk("gap_pending_busy", 24'(busy), 24'h1);
    chk("no_timeout_ever", 24'(n_to), 24'd0);
`endif

    chk("pulse_overlap", 24'(n_overlap), 24'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/receiver3b.md
Name: receiver3b

Overview:
- Serial receiver, directly downstream of the 3-byte UART transmitter.
- Recovers 8N1 frames (start bit 0, 8 data bits LSB first, 1 stop bit) from the serial line using oversampling.
- Assembles three consecutive bytes into one 24-bit word and presents it with a one-cycle valid strobe.
- Transmitter output `out` wires straight to `rx`; the word on `data_out` equals the word that was on the transmitter's `data` input.

Parameters:
- OVERSAMPLE, 16, `clk` cycles per bit period; even, ≥4.
- TIMEOUT_BITS, 10, idle bit periods before a partial word is discarded (used only with RX_TIMEOUT_EN).

Ports:
- clk  input  1  Oversampling clock, OVERSAMPLE × baud; all logic on rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- rx  input  1  Serial line; idles high; asynchronous to clk.
- data_out  output  [0:23]  Last complete word.
- data_valid  output  1  One-cycle pulse when data_out updates.
- frame_error  output  1  One-cycle pulse when a stop bit samples 0.
- timeout  output  1  One-cycle pulse when a partial word is dropped; tied 0 without RX_TIMEOUT_EN.
- busy  output  1  High when state ≠ IDLE or byte_cnt ≠ 0.
- state_out  output  [1:0]  Current state: IDLE=0, START=1, DATA=2, STOP=3.

Behaviour:
- Reset (async, rst_n=0):
  - 2-flop synchronizer on rx and rx_prev reset to 1.
  - state=IDLE; sample_cnt, bit_cnt and byte_cnt=0.
  - data_out=0, data_valid=0, frame_error=0, timeout=0, busy=0.
  - The shift buffer is cleared.
  - Reset mid-frame abandons the partial word; no pulse is emitted.
- Input sync: rx_s is the second synchronizer stage; rx_prev is rx_s delayed one cycle.
- IDLE: a falling edge (rx_prev=1, rx_s=0) → START, sample_cnt=0. A line held low does not retrigger.
- START: sample_cnt increments each clk.
  - At sample_cnt=OVERSAMPLE/2−1, if rx_s=0 → DATA, sample_cnt=0, bit_cnt=0.
  - If rx_s=1 at that point it is a glitch → IDLE, no pulse, byte_cnt unchanged.
- DATA: at sample_cnt=OVERSAMPLE−1 (mid-bit):
  - Store rx_s into buf[23 − (8·byte_cnt + bit_cnt)], then set sample_cnt=0.
  - After bit_cnt=7 is stored → STOP; otherwise bit_cnt increments.
- Resulting byte mapping: byte 0 lands in [16:23], byte 1 in [8:15], byte 2 in [0:7], each MSB at the lowest index.
- STOP: at sample_cnt=OVERSAMPLE−1:
  - If rx_s=1 and byte_cnt=2:
    - data_out ← buf on the next edge; data_valid=1 for exactly one cycle.
    - byte_cnt=0.
  - If rx_s=1 and byte_cnt<2: byte_cnt increments.
  - If rx_s=0:
    - frame_error=1 for one cycle; byte_cnt=0; partial word discarded.
    - data_out is unchanged.
  - In all cases → IDLE.
- Timing: the return to IDLE happens mid-stop-bit, so a start bit that immediately follows (back-to-back bytes) is caught.
- Latency: data_valid is asserted 1 clk after the mid-stop sample of byte 2.
- data_out holds its value until the next successful word; no handshake or back-pressure is required.
- data_valid, frame_error and timeout are never asserted in the same cycle.
- Counters: sample_cnt is $clog2(OVERSAMPLE) bits, bit_cnt is 3 bits, byte_cnt is 2 bits. byte_cnt never reaches 3.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - In IDLE with byte_cnt≠0, an idle counter counts clk cycles. Any falling edge clears it.
  - Reaching TIMEOUT_BITS·OVERSAMPLE → timeout=1 for one cycle, byte_cnt=0, partial discarded, counter cleared.
  - The counter is held at 0 whenever byte_cnt=0 or state≠IDLE.
- Not defined:
  - No counter is built; timeout is constant 0.
  - A partial word waits indefinitely, so bytes separated by any gap combine into one word.

Test Plan (all with OVERSAMPLE=16):
- Clean word: bytes 0xA5, 0x3C, 0x81 sent LSB-first with 1 stop each, back-to-back → single data_valid pulse; data_out=24'h813CA5; frame_error=0; busy returns to 0; state_out=0.
- Glitch: rx low for 4 clks then high, in IDLE → state_out returns to 0 by the mid-start check; no pulses; byte_cnt stays 0.
- Framing error: byte 0x11 OK, then 0x22 with stop bit 0, then line high, then 0x01, 0x02, 0x03 → one frame_error pulse; then one data_valid with data_out=24'h030201.
- Reset mid-frame: rst_n low for 3 clks during DATA of byte 1 → all outputs 0 immediately; then full word 0xFF, 0x00, 0xAA → data_out=24'hAA00FF.
- Timeout (TIMEOUT_BITS=10): byte 0x55, idle 12 bit periods, then 0x01, 0x02, 0x03:
  - With RX_TIMEOUT_EN → timeout pulse ~10 bit periods after byte 0x55; then data_out=24'h030201.
  - Without RX_TIMEOUT_EN → data_valid after the third byte sent (0x02) with data_out=24'h020155; a later 0x03 is left pending.
- Back-to-back words: 0x12, 0x34, 0x56 then 0x9A, 0xBC, 0xDE with no gaps → two data_valid pulses, giving 24'h563412 then 24'hDEBC9A.
